game_flow_ctrl: RTL
===================

// Module: game_flow_ctrl
// PURPOSE
//   Game-flow sequencer for the note generator. Derives the millisecond game clock
//   from clk and drives it onto note_gen's i_cur_time. Holds note_gen in reset
//   until a start countdown expires, then supports pause/resume, abort, and game end.
//   Game end comes from note_gen's o_game_end or from a hard timeout.
// PARAMETERS
//   CYCLES_PER_MS  100_000  clk cycles per game millisecond (>=2)
//   COUNTDOWN_MS   3000     pre-play countdown length in ms (0 = skip countdown)
//   TIME_MAX_MS    180000   PLAY timeout in ms; reaching it forces FINISH
//   TIME_W         32       width of the game-time counter
// PORTS
//   clk           in   1       system clock
//   rst           in   1       synchronous, active-low reset
//   i_start       in   1       1-cycle pulse: start a new game (IDLE/FINISH)
//   i_pause       in   1       1-cycle pulse: toggle PLAY <-> PAUSE
//   i_abort       in   1       1-cycle pulse: return to IDLE from any state
//   i_game_end    in   1       note_gen o_game_end (level or pulse)
//   o_cur_time    out  TIME_W  game time in ms, to note_gen i_cur_time
//   o_note_rst    out  1       active-high reset to note_gen
//   o_ms_tick     out  1       1-cycle pulse per elapsed ms (COUNTDOWN/PLAY only)
//   o_cd_remain   out  16      remaining countdown ms (0 outside COUNTDOWN)
//   o_state       out  3       IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, FINISH=4
//   o_playing     out  1       1 while state==PLAY
//   o_done        out  1       1 while state==FINISH
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=IDLE, prescaler=0, o_cur_time=0, o_cd_remain=0,
//     o_note_rst=1, o_ms_tick=0, o_playing=0, o_done=0. Effective mid-operation too.
//   All outputs are registered and update on the same edge as the state change.
//   Prescaler: counts 0..CYCLES_PER_MS-1 only in COUNTDOWN/PLAY. It wraps to 0 and
//     fires o_ms_tick on the next edge. It is frozen (not cleared) in PAUSE.
//     It is cleared on entry to COUNTDOWN.
//   IDLE: i_start -> COUNTDOWN. Load o_cd_remain=COUNTDOWN_MS and clear o_cur_time.
//     If COUNTDOWN_MS==0, go straight to PLAY.
//   COUNTDOWN: each tick decrements o_cd_remain. The tick that takes it 1->0 also
//     enters PLAY. i_pause and i_start are ignored.
//   PLAY: each tick increments o_cur_time. o_cur_time updates on the edge where
//     o_ms_tick rises. Checks, highest priority first:
//       i_game_end -> FINISH, with no increment that cycle.
//       o_cur_time==TIME_MAX_MS -> FINISH (the increment to TIME_MAX_MS occurs,
//         then FINISH is entered next cycle).
//       i_pause -> PAUSE.
//   PAUSE: o_cur_time held. i_pause -> PLAY, prescaler resumes from its held value.
//     i_game_end is ignored.
//   FINISH: o_cur_time held, o_done=1. i_start -> COUNTDOWN (same as from IDLE).
//   i_abort outranks everything except reset. From any state it goes to IDLE next
//     edge, clears o_cur_time, prescaler and o_cd_remain, and sets o_note_rst=1.
//   o_note_rst=1 in IDLE/COUNTDOWN/FINISH and 0 in PLAY/PAUSE. It falls on the
//     edge that enters PLAY, so note_gen first samples o_cur_time==0 while running.
//   o_cur_time never wraps. It saturates at TIME_MAX_MS.
// TESTING  (CYCLES_PER_MS=4, COUNTDOWN_MS=3, TIME_MAX_MS=20)
//   1. Hold rst=0 for 2 cycles, then pulse i_start. Required: state=1, o_cd_remain
//      steps 3,2,1,0 every 4 cycles. After 12 cycles state=2, o_note_rst=0,
//      o_cur_time=0.
//   2. Stay in PLAY for 40 cycles. Required: 10 o_ms_tick pulses, each 4 cycles
//      apart, and o_cur_time=10.
//   3. Pulse i_pause at o_cur_time=5 and wait 17 cycles. Required: o_cur_time=5,
//      no ticks, o_note_rst=0. Pulse i_pause again. Required: next tick after the
//      remaining prescaler count, not a full 4.
//   4. Raise i_game_end on the cycle of the tick that would make 7 (from 6).
//      Required: FINISH, o_cur_time=6, o_done=1, o_note_rst=1.
//   5. Never assert i_game_end. Required: o_cur_time reaches 20, then FINISH.
//      Then pulse i_start. Required: COUNTDOWN with o_cur_time=0.
//   6. Pulse i_abort while in PAUSE. Required: IDLE. Then set rst=0 during PLAY.
//      Required: all outputs at reset values on the next edge.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: derives the millisecond game clock, runs the start countdown,
// and sequences note_gen through play/pause/finish with abort and timeout handling.
module game_flow_ctrl #(
    parameter int CYCLES_PER_MS = 100_000,
    parameter int COUNTDOWN_MS  = 3000,
    parameter int TIME_MAX_MS   = 180000,
    parameter int TIME_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_abort,
    input  logic              i_game_end,
    output logic [TIME_W-1:0] o_cur_time,
    output logic              o_note_rst,
    output logic              o_ms_tick,
    output logic [15:0]       o_cd_remain,
    output logic [2:0]        o_state,
    output logic              o_playing,
    output logic              o_done
);
    localparam int PW = $clog2(CYCLES_PER_MS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_presc, w_presc_nxt;
    logic [TIME_W-1:0] r_cur_time, w_cur_time_nxt;
    logic [15:0]       r_cd, w_cd_nxt;
    logic              r_tick, w_tick_nxt;
    logic              r_note_rst, r_playing, r_done;
    logic              w_wrap;
    logic [PW-1:0]     w_presc_adv;

    assign w_wrap      = (r_presc == PW'(CYCLES_PER_MS - 1));
    assign w_presc_adv = w_wrap ? '0 : r_presc + PW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_cur_time_nxt = r_cur_time;
        w_cd_nxt       = r_cd;
        w_tick_nxt     = 1'b0;
        if (i_abort) begin
            w_state_nxt    = S_IDLE;
            w_presc_nxt    = '0;
            w_cur_time_nxt = '0;
            w_cd_nxt       = '0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (i_start) begin
                        w_presc_nxt    = '0;
                        w_cur_time_nxt = '0;
                        if (COUNTDOWN_MS == 0) begin
                            w_state_nxt = S_PLAY;
                            w_cd_nxt    = '0;
                        end else begin
                            w_state_nxt = S_COUNTDOWN;
                            w_cd_nxt    = 16'(COUNTDOWN_MS);
                        end
                    end
                end
                S_COUNTDOWN: begin
                    w_presc_nxt = w_presc_adv;
                    if (w_wrap) begin
                        w_tick_nxt = 1'b1;
                        w_cd_nxt   = r_cd - 16'd1;
                        if (r_cd == 16'd1)
                            w_state_nxt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // game end and timeout both freeze the clock on the finishing cycle
                    if (i_game_end || (r_cur_time == TIME_W'(TIME_MAX_MS))) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_presc_nxt = w_presc_adv;
                        if (w_wrap) begin
                            w_tick_nxt     = 1'b1;
                            w_cur_time_nxt = r_cur_time + TIME_W'(1);
                        end
                        if (i_pause)
                            w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (i_pause)
                        w_state_nxt = S_PLAY;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_cur_time <= '0;
            r_cd       <= '0;
            r_tick     <= 1'b0;
            r_note_rst <= 1'b1;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_cur_time <= w_cur_time_nxt;
            r_cd       <= w_cd_nxt;
            r_tick     <= w_tick_nxt;
            r_note_rst <= !((w_state_nxt == S_PLAY) || (w_state_nxt == S_PAUSE));
            r_playing  <= (w_state_nxt == S_PLAY);
            r_done     <= (w_state_nxt == S_FINISH);
        end
    end

    assign o_state     = r_state;
    assign o_cur_time  = r_cur_time;
    assign o_cd_remain = r_cd;
    assign o_ms_tick   = r_tick;
    assign o_note_rst  = r_note_rst;
    assign o_playing   = r_playing;
    assign o_done      = r_done;
endmodule
